// File: rtl/exp_align_offset_n.sv
// N-lane exponent alignment: S1 finds the vector maximum, S2 emits per-lane right-shift offsets.
// Define EXP_OFFSET_SAT_EN to clamp nonzero-lane offsets at MAX_SHIFT.
module exp_align_offset_n #(
    parameter int EXP_WIDTH = 4,
    parameter int LANES     = 4,
    parameter int MAX_SHIFT = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_WIDTH*LANES-1:0]   in_exp,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_WIDTH-1:0]         out_max_exp,
    output logic [EXP_WIDTH*LANES-1:0]   out_offset,
    output logic [LANES-1:0]             out_zero_mask
);

    localparam int DEPTH  = $clog2(LANES);
    localparam int LEAVES = 1 << DEPTH;
    localparam logic [EXP_WIDTH-1:0] SHIFT_CAP = EXP_WIDTH'(MAX_SHIFT);

    logic [EXP_WIDTH-1:0]       tree [1:2*LEAVES-1];
    logic [LANES-1:0]           zero_now;
    logic [EXP_WIDTH*LANES-1:0] s1_exp;
    logic [LANES-1:0]           s1_mask;
    logic [EXP_WIDTH-1:0]       s1_max;
    logic                       v1;
    logic                       v2;
    logic                       load1;
    logic                       load2;
    logic [EXP_WIDTH*LANES-1:0] next_offset;

    // Heap-ordered balanced max tree; padding leaves are zero so they never win.
    always_comb begin
        for (int k = 1; k < 2*LEAVES; k++) begin
            tree[k] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            tree[LEAVES+i] = in_exp[EXP_WIDTH*i +: EXP_WIDTH];
        end
        for (int k = LEAVES-1; k >= 1; k--) begin
            tree[k] = (tree[2*k] >= tree[2*k+1]) ? tree[2*k] : tree[2*k+1];
        end
    end

    always_comb begin
        zero_now = '0;
        for (int i = 0; i < LANES; i++) begin
            zero_now[i] = (in_exp[EXP_WIDTH*i +: EXP_WIDTH] == '0);
        end
    end

    assign load2     = v1 && (!v2 || out_ready);
    assign in_ready  = !v1 || !v2 || out_ready;
    assign load1     = in_valid && in_ready;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_exp  <= '0;
            s1_mask <= '0;
            s1_max  <= '0;
        end else if (load1) begin
            v1      <= 1'b1;
            s1_exp  <= in_exp;
            s1_mask <= zero_now;
            s1_max  <= tree[1];
        end else if (load2) begin
            v1      <= 1'b0;
        end
    end

    // max >= every lane exponent, so the difference never wraps.
    always_comb begin
        logic [EXP_WIDTH-1:0] diff;
        next_offset = '0;
        diff        = '0;
        for (int i = 0; i < LANES; i++) begin
            diff = s1_max - s1_exp[EXP_WIDTH*i +: EXP_WIDTH];
`ifdef EXP_OFFSET_SAT_EN
            if (diff > SHIFT_CAP) begin
                diff = SHIFT_CAP;
            end
`endif
            next_offset[EXP_WIDTH*i +: EXP_WIDTH] = s1_mask[i] ? SHIFT_CAP : diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2            <= 1'b0;
            out_max_exp   <= '0;
            out_offset    <= '0;
            out_zero_mask <= '0;
        end else if (load2) begin
            v2            <= 1'b1;
            out_max_exp   <= s1_max;
            out_offset    <= next_offset;
            out_zero_mask <= s1_mask;
        end else if (out_ready) begin
            v2            <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exp_align_offset_n.sv
// Self-checking bench for exp_align_offset_n: queue-based reference model plus directed literal vectors.
// Expected saturation results follow EXP_OFFSET_SAT_EN.
module tb_exp_align_offset_n;

    localparam int EW = 4;
    localparam int L  = 4;
    localparam int MS = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [EW*L-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_max_exp;
    logic [EW*L-1:0] out_offset;
    logic [L-1:0]  out_zero_mask;

    typedef struct {
        logic [EW-1:0]   mx;
        logic [EW*L-1:0] off;
        logic [L-1:0]    mask;
        int              ready_edge;
    } result_t;

    result_t exp_q[$];
    int      pop_edges[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      edge_cnt   = 0;
    int      pops       = 0;
    logic    held_valid = 1'b0;
    logic [EW-1:0]   held_max;
    logic [EW*L-1:0] held_off;
    logic [L-1:0]    held_mask;

    exp_align_offset_n #(.EXP_WIDTH(EW), .LANES(L), .MAX_SHIFT(MS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
        .out_max_exp(out_max_exp), .out_offset(out_offset), .out_zero_mask(out_zero_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic result_t model(input logic [EW*L-1:0] e);
        result_t r;
        int mx, d, lane;
        mx = 0;
        for (int i = 0; i < L; i++) begin
            lane = int'(e[EW*i +: EW]);
            if (lane > mx) mx = lane;
        end
        r.mx   = EW'(mx);
        r.off  = '0;
        r.mask = '0;
        r.ready_edge = 0;
        for (int i = 0; i < L; i++) begin
            lane = int'(e[EW*i +: EW]);
            if (lane == 0) begin
                r.mask[i] = 1'b1;
                d = MS;
            end else begin
                d = mx - lane;
`ifdef EXP_OFFSET_SAT_EN
                if (d > MS) d = MS;
`endif
            end
            r.off[EW*i +: EW] = EW'(d);
        end
        return r;
    endfunction

    // Reference compare: an item is visible two edges after it is driven, or as soon as its predecessor leaves.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_valid = 1'b0;
        end else begin
            result_t r;
            checkOutput("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
            checkOutput("out_valid", out_valid, exp_q.size() > 0 && edge_cnt >= exp_q[0].ready_edge);
            if (out_valid && exp_q.size() > 0) begin
                checkOutput("model_max", out_max_exp, exp_q[0].mx);
                checkOutput("model_offset", out_offset, exp_q[0].off);
                checkOutput("model_mask", out_zero_mask, exp_q[0].mask);
            end
            if (held_valid && out_valid) begin
                checkOutput("stall_stable", {out_max_exp, out_offset, out_zero_mask},
                            {held_max, held_off, held_mask});
            end
            held_valid = out_valid && !out_ready;
            held_max   = out_max_exp;
            held_off   = out_offset;
            held_mask  = out_zero_mask;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pops++;
                pop_edges.push_back(edge_cnt);
                if (exp_q.size() > 0 && exp_q[0].ready_edge < edge_cnt + 1)
                    exp_q[0].ready_edge = edge_cnt + 1;
            end
            if (in_valid && in_ready) begin
                r = model(in_exp);
                r.ready_edge = edge_cnt + 2;
                exp_q.push_back(r);
            end
        end
    end

    task automatic applyStimulus(input logic [EW*L-1:0] e);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_exp   = e;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic applyAndCheck(input string name, input logic [EW*L-1:0] e,
                                 input logic [EW-1:0] mx, input logic [EW*L-1:0] off,
                                 input logic [L-1:0] mask);
        applyStimulus(e);
        @(negedge clk);
        checkOutput({name, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        checkOutput({name, "_valid"}, out_valid, 1'b1);
        checkOutput({name, "_max"}, out_max_exp, mx);
        checkOutput({name, "_offset"}, out_offset, off);
        checkOutput({name, "_mask"}, out_zero_mask, mask);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        checkOutput(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [EW*L-1:0] vecs [6];
        int idx, low_cnt, pops0, stall_miss;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_exp    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_payload", {out_max_exp, out_offset, out_zero_mask}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyAndCheck("basic", 16'hC073, 4'd12, 16'h0959, 4'b0100);
`ifdef EXP_OFFSET_SAT_EN
        applyAndCheck("sat", 16'hF2F1, 4'd15, 16'h0909, 4'b0000);
`else
        applyAndCheck("sat", 16'hF2F1, 4'd15, 16'h0D0E, 4'b0000);
`endif
        applyAndCheck("allzero", 16'h0000, 4'd0, 16'h9999, 4'b1111);
        applyAndCheck("allequal", 16'h5555, 4'd5, 16'h0000, 4'b0000);
        drain("drain_directed");

        // Back-pressure: six distinct vectors, downstream stalled for cycles 3..6.
        vecs[0] = 16'h1234; vecs[1] = 16'hF00F; vecs[2] = 16'h0A03;
        vecs[3] = 16'h7777; vecs[4] = 16'h1F21; vecs[5] = 16'h0900;
        idx = 0; low_cnt = 0; pops0 = pops;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (idx < 6);
            in_exp    = (idx < 6) ? vecs[idx] : '0;
            @(negedge clk);
            if (!in_ready) low_cnt++;
            if (in_valid && in_ready) idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("drain_bp");
        checkOutput("bp_accepted", idx, 6);
        checkOutput("bp_in_ready_dropped", low_cnt > 0, 1'b1);
        checkOutput("bp_emitted", pops - pops0, 6);

        // Full throughput with random exponents.
        pops0 = pops; stall_miss = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_exp   = EW*L'($urandom);
            @(negedge clk);
            if (!in_ready) stall_miss++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("drain_tp");
        checkOutput("tp_no_stall", stall_miss, 0);
        checkOutput("tp_count", pops - pops0, 32);
        if (pop_edges.size() >= pops0 + 32)
            checkOutput("tp_consecutive", pop_edges[pops0+31] - pop_edges[pops0], 31);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_exp = 16'h3141;
        @(posedge clk); #1;
        in_exp = 16'h2718;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_full", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_in_ready", in_ready, 1'b1);
        checkOutput("midrst_payload", {out_max_exp, out_offset, out_zero_mask}, '0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyAndCheck("post_rst", 16'h8421, 4'd8, 16'h0467, 4'b0000);
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
